font_rom_arbiter: RTL and testbench

Shares one character-font ROM (registered read, 1-cycle latency, 13-bit address = {7-bit char code, 6-bit line}, 8-bit pixel row) between several drawing requesters: the board-number drawer, the timer/mine-counter drawer and the status-text drawer. The block sits between those drawers and the single font ROM instance in the redraw path. It grants at most one address per cycle, pipelines the read and routes each returned row back to its requester with a per-requester valid strobe.

---
 rtl/font_rom_arbiter.sv | 174 +++++++++++++++++
 tb/tb_font_rom_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter
// Shares one registered-read font ROM between several glyph drawers.
// Round-robin arbitration with optional per-requester lock bursts (capped at
// MAX_BURST), a registered ROM address and a two-stage valid/id pipeline that
// steers each returned glyph row back to its requester two cycles after grant.
//
// Handshake: req[i] is held together with its address slice until gnt[i] is
// seen high in the same cycle; dropping req[i] before that withdraws the read.
// Each grant produces exactly one rd_valid[i] pulse two cycles later.
//
// Build option: define FONT_ARB_PRIO0_EN to give requester 0 absolute priority
// over round-robin and over any other requester's lock.
module font_rom_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  // arbitration state
  logic [IDX_W-1:0] last_gnt;
  logic [CNT_W-1:0] burst_cnt;
  logic             prev_gnt;

  // arbitration decision for the current cycle
  logic             lock_hold;
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W:0]   rr_c;
  logic             win_any;
  logic             win_lock;
  logic [IDX_W-1:0] win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [CNT_W-1:0] burst_next;

  // read pipeline
  logic             s1_valid;
  logic [IDX_W-1:0] s1_id;
  logic             s2_valid;
  logic [IDX_W-1:0] s2_id;

  // previous winner keeps the ROM while it still asks and its burst is not used up
  assign lock_hold = prev_gnt && req[last_gnt] && req_lock[last_gnt] &&
                     (burst_cnt < BURST_MAX);

  // round-robin search starting just after last_gnt; nearer offsets overwrite farther ones
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_c     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_c = {1'b0, last_gnt} + (IDX_W+1)'(k);
      if (rr_c >= (IDX_W+1)'(N_REQ)) begin
        rr_c = rr_c - (IDX_W+1)'(N_REQ);
      end
      if (req[rr_c[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_c[IDX_W-1:0];
      end
    end
  end

  // pick the winner: lock first, otherwise round-robin (an expired lock falls through)
  always_comb begin
    win_any  = 1'b0;
    win_idx  = '0;
    win_lock = 1'b0;
    if (lock_hold) begin
      win_any  = 1'b1;
      win_idx  = last_gnt;
      win_lock = 1'b1;
    end else if (rr_found) begin
      win_any  = 1'b1;
      win_idx  = rr_idx;
    end
`ifdef FONT_ARB_PRIO0_EN
    // requester 0 pre-empts everything; its own lock only counts, never rotates it
    if (req[0]) begin
      win_any  = 1'b1;
      win_idx  = '0;
      win_lock = prev_gnt && (last_gnt == '0) && req_lock[0];
    end
`endif
  end

  // burst length after this grant: extend a held lock (saturating), else restart at 1
  always_comb begin
    burst_next = CNT_W'(1);
    if (win_lock) begin
      burst_next = (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + CNT_W'(1);
    end
  end

  // address mux for the winning requester
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // one-hot grant, suppressed while reset is held
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = rst && win_any && (win_idx == IDX_W'(i));
    end
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt  <= LAST_RST;
      burst_cnt <= '0;
      prev_gnt  <= 1'b0;
    end else begin
      prev_gnt <= win_any;
      if (win_any) begin
        last_gnt  <= win_idx;
        burst_cnt <= burst_next;
      end
    end
  end

  // ROM address register and two-stage valid/id pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
    end else begin
      s1_valid <= win_any;
      s1_id    <= win_idx;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (win_any) begin
        rom_addr <= win_addr;
      end
    end
  end

  // route the returned row to its owner; idle-cycle ROM output is masked to 0
  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rd_valid[i] = s2_valid && (s2_id == IDX_W'(i));
    end
    rd_data = s2_valid ? rom_data : '0;
    busy    = s1_valid | s2_valid;
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter
// Directed scenarios followed by randomized traffic, all compared against a
// cycle-level reference model of the arbitration rules and read latency.
module tb_font_rom_arbiter;

  localparam int N  = 3;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            busy;

  int n_checks;
  int n_fail;

  font_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_lock (req_lock),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // font ROM stand-in: registered read of a fixed address hash
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {3'b101, a[12:8]};
  endfunction

  always_ff @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_last;
  int           m_burst;
  bit           m_prev;
  bit           m_v1, m_v2;
  int           m_id1, m_id2;
  logic [AW-1:0] m_rom_addr;
  logic [DW-1:0] m_d2;
  bit           c_any;
  int           c_win;
  bit           c_lockpath;
  logic [N-1:0] obs_gnt;

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_burst = 0; m_prev = 0;
    m_v1 = 0; m_v2 = 0; m_id1 = 0; m_id2 = 0;
    m_rom_addr = '0; m_d2 = '0;
    c_any = 0; c_win = 0; c_lockpath = 0;
  endtask

  task automatic model_pick();
    c_any = 0; c_win = 0; c_lockpath = 0;
    if (m_prev && req[m_last] && req_lock[m_last] && m_burst < MB) begin
      c_any = 1; c_win = m_last; c_lockpath = 1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!c_any && req[(m_last + k) % N]) begin
          c_any = 1; c_win = (m_last + k) % N;
        end
      end
    end
`ifdef FONT_ARB_PRIO0_EN
    if (req[0]) begin
      c_any = 1; c_win = 0;
      c_lockpath = m_prev && (m_last == 0) && req_lock[0];
    end
`endif
  endtask

  task automatic model_advance();
    m_d2 = rom_fn(m_rom_addr);
    m_v2 = m_v1; m_id2 = m_id1;
    m_v1 = c_any; m_id1 = c_win;
    if (c_any) begin
      m_rom_addr = addr_of(c_win);
      m_burst    = c_lockpath ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 1;
      m_last     = c_win;
    end
    m_prev = c_any;
  endtask

  // one clock cycle: inputs already driven; compare at negedge, advance model at posedge
  task automatic run_cycle();
    logic [N-1:0] exp_gnt;
    model_pick();
    exp_gnt = c_any ? N'(1 << c_win) : '0;
    @(negedge clk);
    obs_gnt = gnt;
    check("gnt",      32'(gnt),      32'(exp_gnt));
    check("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    check("rd_valid", 32'(rd_valid), m_v2 ? 32'(1 << m_id2) : 32'd0);
    check("rd_data",  32'(rd_data),  m_v2 ? 32'(m_d2) : 32'd0);
    check("busy",     32'(busy),     32'(m_v1 || m_v2));
    @(posedge clk);
    model_advance();
    #1;
  endtask

  // synchronous-looking reset pulse applied just after a clock edge
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_gnt",      32'(gnt),      32'd0);
    req = '0; req_lock = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (c_any && c_win == i) begin
          req[i] = ($urandom_range(0, 9) < 7);
          req_addr[i*AW +: AW] = AW'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'($urandom);
      end
      if ($urandom_range(0, 3) == 0) req_lock[i] = ~req_lock[i];
    end
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] held_addr;
    n_checks = 0;
    n_fail   = 0;
    obs_gnt  = '0;
    rst      = 1'b0;
    req      = '1;
    req_lock = '0;
    req_addr = '0;
    model_reset();

    // reset state, with requests present: grant must stay low
    @(negedge clk);
    @(negedge clk);
    check("reset_gnt",      32'(gnt),      32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data",  32'(rd_data),  32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    req = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single requester: latency 2 from grant to returned row
    req = 3'b010;
    req_addr[1*AW +: AW] = 13'h0A05;
    run_cycle();
    check("single_gnt", 32'(obs_gnt), 32'h2);
    req = '0;
    repeat (3) run_cycle();

    // all requesting continuously from reset: 001,010,100,...
    do_reset();
    req = 3'b111;
    req_addr = {13'h1ABC, 13'h0123, 13'h0777};
    cnt = 0;
    for (int c = 0; c < 9; c++) begin
      run_cycle();
      if (obs_gnt == N'(1 << (c % N))) cnt++;
    end
    check("rr_sequence", 32'(cnt), 32'd9);

    // reset with reads in flight, then silence after release
    do_reset();
    repeat (4) run_cycle();

    // locked burst by requester 2 against two competitors
    req = 3'b100; req_lock = 3'b100;
    req_addr[2*AW +: AW] = 13'h0F0F;
    run_cycle();
    req = 3'b111;
    cnt = (obs_gnt == 3'b100) ? 1 : 0;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      if (obs_gnt == 3'b100) cnt++;
    end
`ifndef FONT_ARB_PRIO0_EN
    check("burst_len", 32'(cnt), 32'(MB));
`endif
    run_cycle();
`ifndef FONT_ARB_PRIO0_EN
    check("burst_rotate", 32'(obs_gnt), 32'h1);
`endif
    repeat (6) run_cycle();

    // requester 1 bursting, requester 0 arrives in cycle 5
    do_reset();
    req = 3'b010; req_lock = 3'b010;
    repeat (5) run_cycle();
    req = 3'b011;
    run_cycle();
`ifdef FONT_ARB_PRIO0_EN
    check("prio_c5", 32'(obs_gnt), 32'h1);
`else
    check("prio_c5", 32'(obs_gnt), 32'h2);
`endif
    repeat (6) run_cycle();

    // idle: nothing granted, address held
    req = '0; req_lock = '0;
    repeat (3) run_cycle();
    held_addr = rom_addr;
    repeat (10) run_cycle();
    check("idle_rom_addr_hold", 32'(rom_addr), 32'(held_addr));

    // randomized traffic with withdrawals and lock toggling
    for (int c = 0; c < 2000; c++) begin
      drive_random();
      run_cycle();
      if (c % 500 == 499) do_reset();
    end

    req = '0; req_lock = '0;
    repeat (4) run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
